dram_pattern_tester: RTL and testbench
======================================

# dram_pattern_tester

Synthesizable memory traffic generator and checker that drives the DRAM wrapper's Wishbone slave port as a bus master. After a start request it writes a programmable pattern over a contiguous range of words, reads the range back, and compares each word against the regenerated pattern. It reports pass/fail, a saturating error count, the first failing address and an ack timeout flag. It replaces single-word manual bring-up and sits between the board control logic (buttons/UART/ILA) and the wrapper.

## Interface
- WORD_SIZE, 256, data width in bits; multiple of 32.
- ADDR_WIDTH, 25, word-address width.
- ADDR_SHIFT, 7, left shift from word address to byte bus address; ADDR_WIDTH+ADDR_SHIFT ≤ 32.
- START_DELAY, 1000, idle cycles after `initialized_i` before the first transaction.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for `ack_i` per transaction.
---
- sys_clk_100mhz  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- initialized_i  in  1  DRAM calibration complete.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- mode_i  in  3  pattern select; sampled on start.
- seed_i  in  32  LFSR seed; sampled on start.
- base_addr_i  in  ADDR_WIDTH  first word address; sampled on start.
- num_words_i  in  ADDR_WIDTH  words to test; sampled on start.
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls.
- addr_o  out  32  {word_addr, ADDR_SHIFT zeros}, zero-extended to 32 bits.
- data_o  out  WORD_SIZE  write data.
- data_i  in  WORD_SIZE  read data; valid when ack_i=1.
- ack_i  in  1  slave acknowledge.
- busy_o, done_o, pass_o, fail_o, timeout_o  out  1 each  status.
- err_count_o  out  16  mismatching words; saturates at 16'hFFFF.
- first_err_addr_o  out  ADDR_WIDTH  word address of the first mismatch.

## Operation
- Patterns (lane = 32 bits, replicated WORD_SIZE/32 times, i = word index):
  - 0: 8'hA5 in every byte.
  - 1: checkerboard; 8'hA5 bytes for even i, 8'h5A bytes for odd i.
  - 2: address; each lane = word address zero-extended to 32 bits.
  - 3: inverse address; bitwise NOT of mode 2.
  - 4: LFSR; 32-bit Galois, taps 0x80200003, shifted right. Initial state is seed_i, or 1 if seed_i=0. The state advances once per word and is reloaded from the seed at the start of the read phase.
  - 5–7: behave as mode 0.
- Word address = (base + i) mod 2^ADDR_WIDTH; a range wraps past the top of memory.
- FSM states:
  - IDLE: start_i → WAIT_INIT.
  - WAIT_INIT: initialized_i → DELAY.
  - DELAY: count START_DELAY cycles → WR_REQ; if num_words=0, go to DONE instead with pass_o=1.
  - WR_REQ → WR_WAIT.
  - WR_WAIT: on ack, advance i; if the last word, go to RD_REQ with i=0, else WR_REQ.
  - RD_REQ → RD_WAIT.
  - RD_WAIT: on ack → CHECK.
  - CHECK: go to RD_REQ, or to DONE after the last word.
  - DONE: start_i → WAIT_INIT with status cleared.
- Each start clears err_count_o, first_err_addr_o, pass_o, fail_o, timeout_o and done_o.
- In CHECK, a mismatch increments err_count_o (saturating). If it is the first mismatch, it also latches first_err_addr_o.
- In DONE: pass_o = (err_count=0 && !timeout); fail_o = !pass_o. done_o, pass_o and fail_o hold until the next start.
- Timeout: if ack_i has not arrived TIMEOUT_CYCLES cycles into WR_WAIT or RD_WAIT, drop the bus, set timeout_o=1 and fail_o=1, then go to DONE. If ack and timeout expiry occur in the same cycle, the ack wins.
- busy_o=1 in every state except IDLE and DONE.

## Timing
- Reset: all outputs are 0 (cyc_o, stb_o, we_o, addr_o, data_o, status); the FSM goes to IDLE. A mid-transaction reset drops cyc_o/stb_o asynchronously.
- A transaction registers cyc_o=stb_o=1, we_o, addr_o and data_o in the REQ state. These are held stable until the cycle ack_i is sampled high, then cleared on the next edge.
- cyc_o is low for at least one cycle between consecutive transactions.
- Read data is captured on the ack edge and compared one cycle later (CHECK). Per-read cost: 1 REQ cycle + slave latency + 1 CHECK cycle.
- Write acks need no data check; the next WR_REQ follows directly.
- done_o rises one cycle after the last CHECK, or after a timeout abort.

## Test plan
- Mode 0, base 0, 4 words, slave model with 3-cycle ack latency:
  - required: 4 writes at addr_o 0x0, 0x80, 0x100, 0x180 with data {32{8'hA5}};
  - then 4 reads; done_o=1, pass_o=1, err_count_o=0.
- Mode 4, seed 0, 8 words:
  - required: the first write lane is the 32'h1-seeded LFSR output;
  - the read-phase expected sequence equals the write sequence; pass_o=1.
- Mode 2, base 2^25−2, 4 words:
  - required: word addresses 0x1FFFFFE, 0x1FFFFFF, 0x0, 0x1;
  - each lane equals its own word address; pass_o=1.
- Slave corrupts bit 0 of word index 1 and word index 3 on read, mode 1, base 0x10, 4 words:
  - required: err_count_o=2, first_err_addr_o=0x11, fail_o=1.
- Slave never acks the 2nd write, TIMEOUT_CYCLES=16:
  - required: cyc_o drops 16 cycles after the request; timeout_o=1, fail_o=1, done_o=1, err_count_o=0.
- num_words=0; then rst_n low mid-read with a second start pulse during busy_o:
  - required: the first run gives pass_o=1 with no bus activity;
  - the pulse during busy is ignored;
  - on reset, all outputs go to 0 immediately.

Source files
------------

// File: rtl/dram_pattern_tester.sv
// dram_pattern_tester: Wishbone master that writes a pattern over a word range,
// reads it back and compares every word. It reports pass/fail, a saturating
// error count, the first failing word address and an ack-timeout flag.
module dram_pattern_tester #(
  parameter int WORD_SIZE      = 256,
  parameter int ADDR_WIDTH     = 25,
  parameter int ADDR_SHIFT     = 7,
  parameter int START_DELAY    = 1000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  sys_clk_100mhz,
  input  logic                  rst_n,
  input  logic                  initialized_i,
  input  logic                  start_i,
  input  logic [2:0]            mode_i,
  input  logic [31:0]           seed_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] num_words_i,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [31:0]           addr_o,
  output logic [WORD_SIZE-1:0]  data_o,
  input  logic [WORD_SIZE-1:0]  data_i,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam int LANES = WORD_SIZE / 32;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_INIT, S_DELAY, S_WR_REQ, S_WR_WAIT,
    S_RD_REQ, S_RD_WAIT, S_CHECK, S_DONE
  } state_t;

  // Galois LFSR step: shift right, fold taps 0x80200003 in when bit 0 was set.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h00000000);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h00000000) ? 32'h00000001 : s;
  endfunction

  // Word address to byte bus address, zero-extended to 32 bits.
  function automatic logic [31:0] bus_addr(input logic [ADDR_WIDTH-1:0] w);
    logic [31:0] a;
    a = 32'(w);
    return a << ADDR_SHIFT;
  endfunction

  // Expected word for the selected pattern; one 32-bit lane replicated.
  function automatic logic [WORD_SIZE-1:0] pattern_word(input logic [2:0] mode,
                                                        input logic odd,
                                                        input logic [ADDR_WIDTH-1:0] waddr,
                                                        input logic [31:0] lfsr);
    logic [31:0] lane;
    case (mode)
      3'd1:    lane = odd ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      3'd2:    lane = 32'(waddr);
      3'd3:    lane = ~32'(waddr);
      3'd4:    lane = lfsr;
      default: lane = 32'hA5A5A5A5;
    endcase
    return {LANES{lane}};
  endfunction

  state_t                state_r, state_s;
  logic [2:0]            mode_r, mode_s;
  logic [31:0]           seed_r, seed_s;
  logic [31:0]           lfsr_r, lfsr_s;
  logic [ADDR_WIDTH-1:0] base_r, base_s;
  logic [ADDR_WIDTH-1:0] num_r, num_s;
  logic [ADDR_WIDTH-1:0] idx_r, idx_s;
  logic [31:0]           delay_cnt_r, delay_cnt_s;
  logic [31:0]           to_cnt_r, to_cnt_s;
  logic [WORD_SIZE-1:0]  rd_data_r, rd_data_s;
  logic                  cyc_r, cyc_s;
  logic                  we_r, we_s;
  logic [31:0]           addr_r, addr_s;
  logic [WORD_SIZE-1:0]  data_r, data_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  pass_r, pass_s;
  logic                  fail_r, fail_s;
  logic                  timeout_r, timeout_s;
  logic [15:0]           err_r, err_s;
  logic [ADDR_WIDTH-1:0] first_r, first_s;

  logic [ADDR_WIDTH-1:0] word_addr_s;
  logic                  last_word_s;
  logic [WORD_SIZE-1:0]  pattern_s;
  logic                  start_ok_s;
  logic                  to_expired_s;

  assign word_addr_s  = base_r + idx_r;
  assign last_word_s  = (idx_r == (num_r - ADDR_WIDTH'(1'b1)));
  assign pattern_s    = pattern_word(mode_r, idx_r[0], word_addr_s, lfsr_r);
  assign start_ok_s   = start_i && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign to_expired_s = (to_cnt_r == 32'(TIMEOUT_CYCLES - 1));

  // Next-state and next-register computation for the whole sequencer.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    seed_s      = seed_r;
    lfsr_s      = lfsr_r;
    base_s      = base_r;
    num_s       = num_r;
    idx_s       = idx_r;
    delay_cnt_s = delay_cnt_r;
    to_cnt_s    = to_cnt_r;
    rd_data_s   = rd_data_r;
    cyc_s       = cyc_r;
    we_s        = we_r;
    addr_s      = addr_r;
    data_s      = data_r;
    done_s      = done_r;
    pass_s      = pass_r;
    fail_s      = fail_r;
    timeout_s   = timeout_r;
    err_s       = err_r;
    first_s     = first_r;

    if (start_ok_s) begin
      state_s     = S_WAIT_INIT;
      mode_s      = mode_i;
      seed_s      = seed_fix(seed_i);
      lfsr_s      = seed_fix(seed_i);
      base_s      = base_addr_i;
      num_s       = num_words_i;
      idx_s       = '0;
      delay_cnt_s = 32'd0;
      done_s      = 1'b0;
      pass_s      = 1'b0;
      fail_s      = 1'b0;
      timeout_s   = 1'b0;
      err_s       = 16'd0;
      first_s     = '0;
    end else begin
      case (state_r)
        S_IDLE: state_s = S_IDLE;
        S_WAIT_INIT: begin
          if (initialized_i) begin
            state_s     = S_DELAY;
            delay_cnt_s = 32'd0;
          end else begin
            state_s = S_WAIT_INIT;
          end
        end
        S_DELAY: begin
          if ((delay_cnt_r + 32'd1) >= 32'(START_DELAY)) begin
            if (num_r == '0) begin
              state_s = S_DONE;
              done_s  = 1'b1;
              pass_s  = 1'b1;
              fail_s  = 1'b0;
            end else begin
              state_s = S_WR_REQ;
            end
          end else begin
            delay_cnt_s = delay_cnt_r + 32'd1;
          end
        end
        S_WR_REQ: begin
          cyc_s    = 1'b1;
          we_s     = 1'b1;
          addr_s   = bus_addr(word_addr_s);
          data_s   = pattern_s;
          to_cnt_s = 32'd0;
          state_s  = S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (ack_i) begin
            cyc_s  = 1'b0;
            we_s   = 1'b0;
            addr_s = 32'd0;
            data_s = '0;
            if (last_word_s) begin
              idx_s   = '0;
              lfsr_s  = seed_r;
              state_s = S_RD_REQ;
            end else begin
              idx_s   = idx_r + ADDR_WIDTH'(1'b1);
              lfsr_s  = lfsr_step(lfsr_r);
              state_s = S_WR_REQ;
            end
          end else if (to_expired_s) begin
            cyc_s     = 1'b0;
            we_s      = 1'b0;
            addr_s    = 32'd0;
            data_s    = '0;
            timeout_s = 1'b1;
            fail_s    = 1'b1;
            pass_s    = 1'b0;
            done_s    = 1'b1;
            state_s   = S_DONE;
          end else begin
            to_cnt_s = to_cnt_r + 32'd1;
          end
        end
        S_RD_REQ: begin
          cyc_s    = 1'b1;
          we_s     = 1'b0;
          addr_s   = bus_addr(word_addr_s);
          data_s   = '0;
          to_cnt_s = 32'd0;
          state_s  = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (ack_i) begin
            rd_data_s = data_i;
            cyc_s     = 1'b0;
            addr_s    = 32'd0;
            state_s   = S_CHECK;
          end else if (to_expired_s) begin
            cyc_s     = 1'b0;
            addr_s    = 32'd0;
            timeout_s = 1'b1;
            fail_s    = 1'b1;
            pass_s    = 1'b0;
            done_s    = 1'b1;
            state_s   = S_DONE;
          end else begin
            to_cnt_s = to_cnt_r + 32'd1;
          end
        end
        S_CHECK: begin
          if (rd_data_r != pattern_s) begin
            err_s = (err_r == 16'hFFFF) ? err_r : (err_r + 16'd1);
            if (err_r == 16'd0) begin
              first_s = word_addr_s;
            end else begin
              first_s = first_r;
            end
          end else begin
            err_s = err_r;
          end
          if (last_word_s) begin
            state_s = S_DONE;
            done_s  = 1'b1;
            pass_s  = (err_s == 16'd0) && !timeout_r;
            fail_s  = !((err_s == 16'd0) && !timeout_r);
          end else begin
            idx_s   = idx_r + ADDR_WIDTH'(1'b1);
            lfsr_s  = lfsr_step(lfsr_r);
            state_s = S_RD_REQ;
          end
        end
        S_DONE:  state_s = S_DONE;
        default: state_s = S_IDLE;
      endcase
    end

    busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
  end

  // FSM state register.
  always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, bus and status registers; reset clears the bus immediately.
  always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= 3'd0;
      seed_r      <= 32'd0;
      lfsr_r      <= 32'd0;
      base_r      <= '0;
      num_r       <= '0;
      idx_r       <= '0;
      delay_cnt_r <= 32'd0;
      to_cnt_r    <= 32'd0;
      rd_data_r   <= '0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      data_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timeout_r   <= 1'b0;
      err_r       <= 16'd0;
      first_r     <= '0;
    end else begin
      mode_r      <= mode_s;
      seed_r      <= seed_s;
      lfsr_r      <= lfsr_s;
      base_r      <= base_s;
      num_r       <= num_s;
      idx_r       <= idx_s;
      delay_cnt_r <= delay_cnt_s;
      to_cnt_r    <= to_cnt_s;
      rd_data_r   <= rd_data_s;
      cyc_r       <= cyc_s;
      we_r        <= we_s;
      addr_r      <= addr_s;
      data_r      <= data_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_r      <= fail_s;
      timeout_r   <= timeout_s;
      err_r       <= err_s;
      first_r     <= first_s;
    end
  end

  assign cyc_o            = cyc_r;
  assign stb_o            = cyc_r;
  assign we_o             = we_r;
  assign addr_o           = addr_r;
  assign data_o           = data_r;
  assign busy_o           = busy_r;
  assign done_o           = done_r;
  assign pass_o           = pass_r;
  assign fail_o           = fail_r;
  assign timeout_o        = timeout_r;
  assign err_count_o      = err_r;
  assign first_err_addr_o = first_r;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Bench for dram_pattern_tester: a Wishbone slave model with programmable
// latency, read corruption and a dropped write; a directed table, random
// vectors and hand-written start-while-busy / reset sequences.
module tb_dram_pattern_tester;

  localparam int WS    = 256;
  localparam int AW    = 25;
  localparam int SH    = 7;
  localparam int SD    = 4;
  localparam int TO    = 16;
  localparam int LANES = WS / 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          initialized_i = 1'b0;
  logic          start_i = 1'b0;
  logic [2:0]    mode_i = 3'd0;
  logic [31:0]   seed_i = 32'd0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-1:0] num_words_i = '0;
  logic          cyc_o, stb_o, we_o;
  logic [31:0]   addr_o;
  logic [WS-1:0] data_o;
  logic [WS-1:0] data_i = '0;
  logic          ack_i = 1'b0;
  logic          busy_o, done_o, pass_o, fail_o, timeout_o;
  logic [15:0]   err_count_o;
  logic [AW-1:0] first_err_addr_o;

  dram_pattern_tester #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .ADDR_SHIFT(SH),
    .START_DELAY(SD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk_100mhz(clk), .rst_n(rst_n), .initialized_i(initialized_i),
    .start_i(start_i), .mode_i(mode_i), .seed_i(seed_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o),
    .data_o(data_o), .data_i(data_i), .ack_i(ack_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .timeout_o(timeout_o), .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [WS-1:0] data;
  } txn_t;

  typedef struct {
    logic [2:0]    mode;
    logic [31:0]   seed;
    logic [AW-1:0] base;
    logic [AW-1:0] num;
    int            lat;
    logic [7:0]    mask;
    int            drop;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_first;
    logic          exp_pass;
    logic          exp_to;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // slave model state
  int            lat = 1;
  int            drop_wr = -1;
  logic [7:0]    corrupt_mask = 8'h00;
  int            wr_ord = 0;
  int            rd_ord = 0;
  int            wcnt = 0;
  int            cyc_len = 0;
  int            proto_err = 0;
  bit            in_txn = 1'b0;
  txn_t          cur;
  txn_t          log_q[$];
  logic [WS-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] s_waddr;
  logic [WS-1:0] s_d;

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wishbone slave on the falling edge: logs each request, checks the
  // request is held stable, acks after `lat` cycles and corrupts reads.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_i  = 1'b0;
      in_txn = 1'b0;
      wcnt   = 0;
    end else if (ack_i) begin
      ack_i  = 1'b0;
      in_txn = 1'b0;
      if (cyc_o) proto_err++;
    end else if (cyc_o && stb_o) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        wcnt     = 0;
        cyc_len  = 0;
        cur.we   = we_o;
        cur.addr = addr_o;
        cur.data = data_o;
        log_q.push_back(cur);
      end else if (cur.we !== we_o || cur.addr !== addr_o || (cur.we && cur.data !== data_o)) begin
        proto_err++;
      end
      cyc_len++;
      wcnt++;
      if (wcnt >= lat && !(we_o && wr_ord == drop_wr)) begin
        ack_i   = 1'b1;
        s_waddr = addr_o[SH+AW-1:SH];
        if (we_o) begin
          mem[s_waddr] = data_o;
          wr_ord++;
        end else begin
          s_d = mem.exists(s_waddr) ? mem[s_waddr] : '0;
          if (rd_ord < 8 && corrupt_mask[rd_ord]) s_d[0] = ~s_d[0];
          data_i = s_d;
          rd_ord++;
        end
      end
    end else begin
      in_txn = 1'b0;
    end
  end

  // Reference pattern straight from the pattern definitions; the LFSR is
  // re-run from the seed for every word.
  function automatic logic [WS-1:0] model_word(input logic [2:0] mode, input logic [31:0] seed,
                                               input logic [AW-1:0] base, input int i);
    logic [31:0]   lane;
    logic [31:0]   s;
    logic [AW-1:0] wa;
    wa = base + AW'(i);
    case (mode)
      3'd1: lane = (i % 2 == 1) ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      3'd2: lane = 32'(wa);
      3'd3: lane = ~32'(wa);
      3'd4: begin
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        lane = s;
      end
      default: lane = 32'hA5A5A5A5;
    endcase
    return {LANES{lane}};
  endfunction

  function automatic vec_t model_status(input vec_t v);
    vec_t r;
    r = v;
    r.exp_err   = 16'd0;
    r.exp_first = '0;
    for (int i = 0; i < int'(v.num) && i < 8; i++) begin
      if (v.mask[i]) begin
        if (r.exp_err == 16'd0) r.exp_first = v.base + AW'(i);
        r.exp_err = r.exp_err + 16'd1;
      end
    end
    r.exp_to   = 1'b0;
    r.exp_pass = (r.exp_err == 16'd0);
    return r;
  endfunction

  task automatic start_run(input vec_t v);
    log_q.delete();
    mem.delete();
    wr_ord       = 0;
    rd_ord       = 0;
    proto_err    = 0;
    lat          = v.lat;
    drop_wr      = v.drop;
    corrupt_mask = v.mask;
    @(posedge clk); #1;
    mode_i      = v.mode;
    seed_i      = v.seed;
    base_addr_i = v.base;
    num_words_i = v.num;
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 5000 && !done_o; k++) @(posedge clk) #1;
    if (!done_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_done_wait: done_o still %0b after %0d cycles, required 1", name, done_o, k);
    end
  endtask

  task automatic check_results(input string name, input vec_t v);
    int nw;
    int n_exp;
    int i;
    logic [AW-1:0] wa;
    nw    = int'(v.num);
    n_exp = (v.drop >= 0) ? v.drop + 1 : 2 * nw;
    chk({name, "_done"},    done_o, 1'b1);
    chk({name, "_pass"},    pass_o, v.exp_pass);
    chk({name, "_fail"},    fail_o, !v.exp_pass);
    chk({name, "_timeout"}, timeout_o, v.exp_to);
    chk({name, "_errcnt"},  err_count_o, v.exp_err);
    chk({name, "_first"},   first_err_addr_o, v.exp_first);
    chk({name, "_busy"},    busy_o, 1'b0);
    chk({name, "_proto"},   proto_err, 0);
    chk({name, "_loglen"},  log_q.size(), n_exp);
    for (int j = 0; j < log_q.size() && j < n_exp; j++) begin
      i  = (j < nw) ? j : j - nw;
      wa = v.base + AW'(i);
      chk($sformatf("%s_t%0d_we", name, j), log_q[j].we, (j < nw));
      chk($sformatf("%s_t%0d_addr", name, j), log_q[j].addr, 32'(wa) << SH);
      if (j < nw) chk($sformatf("%s_t%0d_data", name, j), log_q[j].data, model_word(v.mode, v.seed, v.base, i));
    end
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    tbl[0] = '{3'd0, 32'd0,        25'h0000000, 25'd4, 3, 8'h00, -1, 16'd0, 25'h0000000, 1'b1, 1'b0};
    tbl[1] = '{3'd4, 32'd0,        25'h0000000, 25'd8, 2, 8'h00, -1, 16'd0, 25'h0000000, 1'b1, 1'b0};
    tbl[2] = '{3'd2, 32'd0,        25'h1FFFFFE, 25'd4, 1, 8'h00, -1, 16'd0, 25'h0000000, 1'b1, 1'b0};
    tbl[3] = '{3'd1, 32'd0,        25'h0000010, 25'd4, 2, 8'h0A, -1, 16'd2, 25'h0000011, 1'b0, 1'b0};
    tbl[4] = '{3'd0, 32'd0,        25'h0000005, 25'd4, 1, 8'h00,  1, 16'd0, 25'h0000000, 1'b0, 1'b1};
    tbl[5] = '{3'd3, 32'd0,        25'h0000123, 25'd3, 4, 8'h01, -1, 16'd1, 25'h0000123, 1'b0, 1'b0};
    tbl[6] = '{3'd6, 32'h12345678, 25'h0000007, 25'd2, 1, 8'h00, -1, 16'd0, 25'h0000000, 1'b1, 1'b0};

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cyc", cyc_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_status", {done_o, pass_o, fail_o, timeout_o, err_count_o}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // num_words = 0, waiting for calibration first
    v = '{3'd0, 32'd0, 25'h0000040, 25'd0, 1, 8'h00, -1, 16'd0, 25'h0, 1'b1, 1'b0};
    start_run(v);
    repeat (10) @(posedge clk);
    #1;
    chk("init_wait_busy", busy_o, 1'b1);
    chk("init_wait_cyc", cyc_o, 1'b0);
    initialized_i = 1'b1;
    wait_done("zero");
    check_results("zero", v);

    // directed table
    for (int t = 0; t < 7; t++) begin
      start_run(tbl[t]);
      wait_done($sformatf("tbl%0d", t));
      check_results($sformatf("tbl%0d", t), tbl[t]);
      if (tbl[t].mode == 3'd4 && tbl[t].seed == 32'd0 && log_q.size() > 0)
        chk("lfsr_first_lane", log_q[0].data[31:0], 32'h00000001);
      if (tbl[t].drop >= 0) chk("timeout_cyc_len", cyc_len, TO);
    end

    // random vectors against the reference model
    for (int r = 0; r < 12; r++) begin
      v.mode = 3'($urandom_range(0, 7));
      v.seed = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      v.base = AW'($urandom);
      if ($urandom_range(0, 3) == 0) v.base = AW'(33554432 - $urandom_range(1, 5));
      v.num  = AW'($urandom_range(0, 10));
      v.lat  = $urandom_range(1, 4);
      v.mask = 8'($urandom_range(0, 255));
      v.drop = -1;
      v = model_status(v);
      start_run(v);
      wait_done($sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r), v);
    end

    // a start pulse with different settings while busy must be ignored
    v = '{3'd0, 32'd0, 25'h0000100, 25'd8, 2, 8'h00, -1, 16'd0, 25'h0, 1'b1, 1'b0};
    start_run(v);
    for (int k = 0; k < 500 && log_q.size() < 2; k++) @(posedge clk);
    #1;
    mode_i      = 3'd2;
    base_addr_i = 25'h0000400;
    num_words_i = 25'd3;
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done("busy_start");
    check_results("busy_start", v);

    // asynchronous reset in the middle of a read
    v = '{3'd1, 32'd0, 25'h0000200, 25'd8, 3, 8'h00, -1, 16'd0, 25'h0, 1'b1, 1'b0};
    start_run(v);
    for (int k = 0; k < 1000 && !(log_q.size() >= 10 && cyc_o); k++) @(negedge clk);
    chk("midread_cyc_before", {cyc_o, we_o}, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_bus", {cyc_o, stb_o, we_o}, 3'b000);
    chk("mrst_addr", addr_o, 32'd0);
    chk("mrst_data", data_o, '0);
    chk("mrst_status", {busy_o, done_o, pass_o, fail_o, timeout_o}, 5'b00000);
    chk("mrst_cnt", {err_count_o, first_err_addr_o}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", {busy_o, cyc_o}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
